// File: rtl/dispatcher_pkg.sv
// Shared encodings for the framebuffer instruction dispatcher.
// Opcodes match the memory controller's operation input; error codes
// and FSM states are exported so the bench and top agree on them.
package dispatcher_pkg;

   // Controller operation encodings
   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_RD  = 3'b001;
   localparam logic [2:0] OP_WR  = 3'b010;
   localparam logic [2:0] OP_NHI = 3'b011;
   localparam logic [2:0] OP_PR  = 3'b100;
   localparam logic [2:0] OP_NH  = 3'b101;
   localparam logic [2:0] OP_BA  = 3'b110;
   localparam logic [2:0] OP_ILL = 3'b111;

   // Status error codes reported to the HPS
   localparam logic [2:0] ERR_NONE    = 3'b000;
   localparam logic [2:0] ERR_OPCODE  = 3'b001;
   localparam logic [2:0] ERR_ADDR    = 3'b010;
   localparam logic [2:0] ERR_ZOOM    = 3'b011;
   localparam logic [2:0] ERR_TIMEOUT = 3'b100;

   // FSM state encodings
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_DECODE    = 3'd1;
   localparam logic [2:0] ST_ISSUE     = 3'd2;
   localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
   localparam logic [2:0] ST_WAIT_DONE = 3'd4;
   localparam logic [2:0] ST_FINISH    = 3'd5;

   // Instruction word field positions (bit 28 is reserved and ignored)
   localparam int INSTR_W  = 29;
   localparam int OPC_LSB  = 0;
   localparam int OPC_MSB  = 2;
   localparam int ADDR_LSB = 3;
   localparam int ADDR_MSB = 19;
   localparam int COL_LSB  = 20;
   localparam int COL_MSB  = 27;
   localparam int RSVD_BIT = 28;

   typedef logic [2:0] opcode_t;

   // Opcodes that touch a framebuffer address
   function automatic logic is_mem_op(input opcode_t op);
      return (op == OP_RD) || (op == OP_WR);
   endfunction

   // Opcodes that raise the zoom level
   function automatic logic is_zoom_in(input opcode_t op);
      return (op == OP_NHI) || (op == OP_PR);
   endfunction

   // Opcodes that lower the zoom level
   function automatic logic is_zoom_out(input opcode_t op);
      return (op == OP_NH) || (op == OP_BA);
   endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Optional start synchroniser followed by a rising-edge detector.
// Latency: SYNC_STAGES cycles plus combinational edge output; default 0 stages.
// No backpressure: the edge register updates every cycle regardless of consumer.
module edge_detect_rise #(
   parameter int SYNC_STAGES = 0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic sig_in,
   output logic rise
);

   logic sig_s;
   logic sig_q;

   if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Synchroniser chain resets high so a level held through reset is not an edge
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            sync_q <= '1;
         end else begin
            sync_q[0] <= sig_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
               sync_q[i] <= sync_q[i-1];
            end
         end
      end

      assign sig_s = sync_q[SYNC_STAGES-1];
   end else begin : g_direct
      assign sig_s = sig_in;
   end

   // Previous-value register; reset to 1 so start high out of reset is ignored
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sig_q <= 1'b1;
      end else begin
         sig_q <= sig_s;
      end
   end

   assign rise = sig_s & ~sig_q;

endmodule

// File: rtl/instruction_dispatcher.sv
// Decodes one HPS instruction per start edge and drives the framebuffer controller.
// Latency: start edge at N -> mc_enable in cycle N+2 if controller idle; done 2 cycles after mc_done returns.
// Backpressure: holds in ISSUE while mc_done is low; start edges while busy are dropped.
// Optional watchdog on the controller handshake: define DISPATCH_WATCHDOG_EN.
module instruction_dispatcher
   import dispatcher_pkg::*;
#(
   parameter int ADDR_W         = 17,
   parameter int IMG_WIDTH      = 320,
   parameter int IMG_HEIGHT     = 240,
   parameter int ZOOM_MIN       = 0,
   parameter int ZOOM_MAX       = 4,
   parameter int ZOOM_RESET     = 2,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [28:0]       instr,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [2:0]        error_code,
   output logic [7:0]        rd_data,
   output logic [2:0]        zoom_level,
   output logic [2:0]        mc_operation,
   output logic [ADDR_W-1:0] mc_addr,
   output logic [7:0]        mc_color,
   output logic              mc_enable,
   input  logic              mc_done,
   input  logic [7:0]        mc_color_in
);

   localparam logic [ADDR_W:0] PIX_LIMIT  = (ADDR_W+1)'(IMG_WIDTH * IMG_HEIGHT);
   localparam logic [2:0]      ZMIN       = 3'(ZOOM_MIN);
   localparam logic [2:0]      ZMAX       = 3'(ZOOM_MAX);
   localparam logic [2:0]      ZRST       = 3'(ZOOM_RESET);

   logic              start_rise;
   logic [2:0]        state;
   logic [27:0]       instr_q;
   opcode_t           dec_op;
   logic [ADDR_W-1:0] dec_addr;
   logic [7:0]        dec_col;
   logic              addr_oob;
   logic              zoom_block;
   logic              in_wait;
   logic              wd_hit;
   logic              unused_rsvd;

   // The reserved bit is never latched
   assign unused_rsvd = instr[RSVD_BIT];

   edge_detect_rise #(
      .SYNC_STAGES (0)
   ) u_start_edge (
      .clock   (clock),
      .reset_n (reset_n),
      .sig_in  (start),
      .rise    (start_rise)
   );

   assign dec_op     = instr_q[OPC_MSB:OPC_LSB];
   assign dec_addr   = instr_q[ADDR_MSB:ADDR_LSB];
   assign dec_col    = instr_q[COL_MSB:COL_LSB];
   assign addr_oob   = ({1'b0, dec_addr} >= PIX_LIMIT);
   assign zoom_block = (is_zoom_in(dec_op)  && (zoom_level == ZMAX)) ||
                       (is_zoom_out(dec_op) && (zoom_level == ZMIN));
   assign in_wait    = (state == ST_WAIT_ACK) || (state == ST_WAIT_DONE);

`ifdef DISPATCH_WATCHDOG_EN
   localparam logic [20:0] WD_LAST = 21'(TIMEOUT_CYCLES - 1);
   logic [20:0] wd_cnt;

   // Count cycles spent waiting on the controller; restart outside the waits
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt <= '0;
      end else if (in_wait) begin
         wd_cnt <= wd_cnt + 21'd1;
      end else begin
         wd_cnt <= '0;
      end
   end

   assign wd_hit = in_wait && (wd_cnt == WD_LAST);
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT_CYCLES);
   assign wd_hit         = 1'b0;
`endif

   // Dispatch FSM: accept, decode/validate, issue, handshake, report status
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         instr_q      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         error_code   <= ERR_NONE;
         rd_data      <= '0;
         zoom_level   <= ZRST;
         mc_operation <= OP_NOP;
         mc_addr      <= '0;
         mc_color     <= '0;
         mc_enable    <= 1'b0;
      end else begin
         mc_enable <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_rise) begin
                  instr_q    <= instr[27:0];
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  error_code <= ERR_NONE;
                  state      <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (dec_op == OP_ILL) begin
                  error      <= 1'b1;
                  error_code <= ERR_OPCODE;
                  state      <= ST_FINISH;
               end else if (is_mem_op(dec_op) && addr_oob) begin
                  error      <= 1'b1;
                  error_code <= ERR_ADDR;
                  state      <= ST_FINISH;
               end else if (zoom_block) begin
                  error      <= 1'b1;
                  error_code <= ERR_ZOOM;
                  state      <= ST_FINISH;
               end else if (dec_op == OP_NOP) begin
                  state <= ST_FINISH;
               end else begin
                  // Held until the next accepted instruction; controller samples throughout
                  mc_operation <= dec_op;
                  mc_addr      <= dec_addr;
                  mc_color     <= dec_col;
                  state        <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (mc_done) begin
                  mc_enable <= 1'b1;
                  state     <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (!mc_done) begin
                  state <= ST_WAIT_DONE;
               end else if (wd_hit) begin
                  error      <= 1'b1;
                  error_code <= ERR_TIMEOUT;
                  state      <= ST_FINISH;
               end
            end
            ST_WAIT_DONE: begin
               if (mc_done) begin
                  if (mc_operation == OP_RD) begin
                     rd_data <= mc_color_in;
                  end
                  if (is_zoom_in(mc_operation)) begin
                     zoom_level <= zoom_level + 3'd1;
                  end else if (is_zoom_out(mc_operation)) begin
                     zoom_level <= zoom_level - 3'd1;
                  end
                  state <= ST_FINISH;
               end else if (wd_hit) begin
                  error      <= 1'b1;
                  error_code <= ERR_TIMEOUT;
                  state      <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Directed bench for instruction_dispatcher with a simple controller model.
// The model drops mc_done one cycle after enable and restores it three cycles later,
// or never drops it when mdl_hang is set.
module tb_instruction_dispatcher;

   logic        clock;
   logic        reset_n;
   logic [28:0] instr;
   logic        start;
   logic        busy, done, error;
   logic [2:0]  error_code;
   logic [7:0]  rd_data;
   logic [2:0]  zoom_level;
   logic [2:0]  mc_operation;
   logic [16:0] mc_addr;
   logic [7:0]  mc_color;
   logic        mc_enable;
   logic        mc_done;
   logic [7:0]  mc_color_in;

   int          pass_cnt = 0;
   int          chk_cnt  = 0;
   int          en_cnt   = 0;
   int          e0;
   logic [2:0]  cap_op;
   logic [16:0] cap_addr;
   logic [7:0]  cap_col;
   logic        mdl_hang;
   logic [2:0]  mdl_cnt;

   instruction_dispatcher #(
      .ADDR_W         (17),
      .IMG_WIDTH      (320),
      .IMG_HEIGHT     (240),
      .ZOOM_MIN       (0),
      .ZOOM_MAX       (4),
      .ZOOM_RESET     (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .instr        (instr),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .error_code   (error_code),
      .rd_data      (rd_data),
      .zoom_level   (zoom_level),
      .mc_operation (mc_operation),
      .mc_addr      (mc_addr),
      .mc_color     (mc_color),
      .mc_enable    (mc_enable),
      .mc_done      (mc_done),
      .mc_color_in  (mc_color_in)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Controller model handshake
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mc_done <= 1'b1;
         mdl_cnt <= 3'd0;
      end else if (mc_enable && !mdl_hang) begin
         mc_done <= 1'b0;
         mdl_cnt <= 3'd3;
      end else if (mdl_cnt == 3'd1) begin
         mc_done <= 1'b1;
         mdl_cnt <= 3'd0;
      end else if (mdl_cnt != 3'd0) begin
         mdl_cnt <= mdl_cnt - 3'd1;
      end
   end

   // Enable pulse counter and request capture
   always @(posedge clock) begin
      if (mc_enable) begin
         en_cnt   <= en_cnt + 1;
         cap_op   <= mc_operation;
         cap_addr <= mc_addr;
         cap_col  <= mc_color;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 200; i++) begin
         if (done && !busy) break;
         @(negedge clock);
      end
      check(tag, {30'd0, done, busy}, 32'h2);
   endtask

   task automatic run_instr(input logic [2:0] op, input logic [16:0] addr,
                            input logic [7:0] col, input string tag);
      @(negedge clock);
      instr = {1'b0, col, addr, op};
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_done(tag);
   endtask

   task automatic wait_mc_low(input string tag);
      for (int i = 0; i < 20; i++) begin
         if (!mc_done) break;
         @(negedge clock);
      end
      check(tag, {31'd0, mc_done}, 32'd0);
   endtask

   initial begin
      reset_n     = 1'b0;
      start       = 1'b1;
      instr       = '0;
      mc_color_in = 8'h00;
      mdl_hang    = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // Reset values, with start already high
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {29'd0, error, error_code}, 32'd0);
      check("rst_rd_data", {24'd0, rd_data}, 32'd0);
      check("rst_zoom", {29'd0, zoom_level}, 32'd2);
      check("rst_mc", {mc_enable, mc_operation, mc_color, 3'd0, mc_addr}, 32'd0);
      repeat (4) @(negedge clock);
      check("start_high_no_trigger", {31'd0, busy}, 32'd0);
      check("start_high_no_enable", en_cnt, 32'd0);
      start = 1'b0;
      @(negedge clock);

      // WR addr 100 colour A5, reserved bit set, with cycle-exact enable
      e0    = en_cnt;
      instr = {1'b1, 8'hA5, 17'd100, 3'b010};
      start = 1'b1;
      @(negedge clock);
      check("wr_busy", {31'd0, busy}, 32'd1);
      check("wr_en_n0", {31'd0, mc_enable}, 32'd0);
      start = 1'b0;
      @(negedge clock);
      check("wr_en_n1", {31'd0, mc_enable}, 32'd0);
      @(negedge clock);
      check("wr_en_n2", {31'd0, mc_enable}, 32'd1);
      check("wr_mc_fields", {mc_operation, mc_color, mc_addr}, {4'd0, 3'b010, 8'hA5, 17'd100});
      @(negedge clock);
      check("wr_en_single", {31'd0, mc_enable}, 32'd0);
      wait_done("wr_done");
      check("wr_error", {29'd0, error, error_code}, 32'd0);
      check("wr_en_count", en_cnt - e0, 32'd1);
      check("wr_cap", {cap_op, cap_col, cap_addr}, {4'd0, 3'b010, 8'hA5, 17'd100});

      // RD at the last legal address
      e0          = en_cnt;
      mc_color_in = 8'h3C;
      run_instr(3'b001, 17'd76799, 8'h00, "rd_done");
      check("rd_data", {24'd0, rd_data}, 32'h3C);
      check("rd_error", {29'd0, error, error_code}, 32'd0);
      check("rd_cap_op", {29'd0, cap_op}, 32'd1);
      check("rd_en_count", en_cnt - e0, 32'd1);

      // RD one past the end of the frame
      e0          = en_cnt;
      mc_color_in = 8'h77;
      run_instr(3'b001, 17'd76800, 8'h00, "rd_oob_done");
      check("rd_oob_error", {29'd0, error, error_code}, 32'hA);
      check("rd_oob_no_en", en_cnt - e0, 32'd0);
      check("rd_oob_rd_hold", {24'd0, rd_data}, 32'h3C);

      // Zoom in to the limit, then out
      run_instr(3'b100, 17'd0, 8'h00, "pr1_done");
      check("pr1_zoom", {29'd0, zoom_level}, 32'd3);
      run_instr(3'b100, 17'd0, 8'h00, "pr2_done");
      check("pr2_zoom", {29'd0, zoom_level}, 32'd4);
      e0 = en_cnt;
      run_instr(3'b100, 17'd0, 8'h00, "pr3_done");
      check("pr3_error", {29'd0, error, error_code}, 32'hB);
      check("pr3_zoom", {29'd0, zoom_level}, 32'd4);
      check("pr3_no_en", en_cnt - e0, 32'd0);
      run_instr(3'b110, 17'd0, 8'h00, "ba_done");
      check("ba_zoom", {29'd0, zoom_level}, 32'd3);
      check("ba_cap_op", {29'd0, cap_op}, 32'd6);

      // Illegal opcode and NOP
      e0 = en_cnt;
      run_instr(3'b111, 17'd10, 8'h11, "ill_done");
      check("ill_error", {29'd0, error, error_code}, 32'h9);
      check("ill_no_en", en_cnt - e0, 32'd0);
      run_instr(3'b000, 17'd10, 8'h11, "nop_done");
      check("nop_error", {29'd0, error, error_code}, 32'd0);
      check("nop_no_en", en_cnt - e0, 32'd0);

      // Second start edge while waiting on the controller is dropped
      e0 = en_cnt;
      @(negedge clock);
      instr = {1'b0, 8'h5A, 17'd5, 3'b010};
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_mc_low("busy_mc_low");
      instr = {1'b0, 8'h00, 17'd7, 3'b001};
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_done("busy_first_done");
      repeat (10) @(negedge clock);
      check("busy_second_dropped", {31'd0, busy}, 32'd0);
      check("busy_en_count", en_cnt - e0, 32'd1);
      check("busy_cap", {cap_op, cap_addr}, {12'd0, 3'b010, 17'd5});

      // Reset asserted in WAIT_DONE
      @(negedge clock);
      instr = {1'b0, 8'hC3, 17'd9, 3'b010};
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_mc_low("mid_rst_mc_low");
      @(negedge clock);
      check("mid_rst_busy_before", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      @(negedge clock);
      check("mid_rst_status", {27'd0, busy, done, error, error_code == 3'd0, 1'b0}, 32'h2);
      check("mid_rst_zoom", {29'd0, zoom_level}, 32'd2);
      check("mid_rst_rd", {24'd0, rd_data}, 32'd0);
      check("mid_rst_mc", {mc_enable, mc_operation, mc_color, 3'd0, mc_addr}, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

`ifdef DISPATCH_WATCHDOG_EN
      // Controller never acknowledges: watchdog must end the instruction
      mdl_hang    = 1'b1;
      e0          = en_cnt;
      mc_color_in = 8'hEE;
      run_instr(3'b011, 17'd0, 8'h00, "wd_done");
      check("wd_error", {29'd0, error, error_code}, 32'hC);
      check("wd_zoom", {29'd0, zoom_level}, 32'd2);
      check("wd_rd_hold", {24'd0, rd_data}, 32'd0);
      check("wd_en_count", en_cnt - e0, 32'd1);
      mdl_hang = 1'b0;
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
